// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues EX/MEM loads/stores on a req/ack data port and fills MEM/WB.
// Optional build macro MEM_MISALIGN_TRAP_EN traps memory ops whose address is not 8-byte aligned.
//
// state  | meaning
// IDLE   | accepting EX/MEM; ALU ops pass to WB, memory ops are captured
// ACCESS | request registers on the memory port, waiting for mem_ack
module mem_stage_ctrl #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic              MemWrite,
  input  logic [DATA_W-1:0] AluOut,
  input  logic [DATA_W-1:0] DataOut,
  input  logic [REG_W-1:0]  Rd_in,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic              RegWrite_Out,
  output logic              MemtoReg_Out,
  output logic [DATA_W-1:0] ReadData,
  output logic [DATA_W-1:0] AluResult_Out,
  output logic [REG_W-1:0]  Rd_out,
  output logic              misalign_fault
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state, state_nxt;

  logic              mem_op;
  logic              misalign;
  logic              capture;
  logic              wb_alu_load;
  logic              wb_mem_load;
  logic              wb_trap_load;
  logic              req_we;
  logic              req_regwrite;
  logic              req_memtoreg;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [REG_W-1:0]  req_rd;

  assign mem_op = in_valid & (MemtoReg | MemWrite);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = mem_op & (AluOut[2:0] != 3'b000);
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    stall        = 1'b0;
    mem_req      = 1'b0;
    capture      = 1'b0;
    wb_alu_load  = 1'b0;
    wb_mem_load  = 1'b0;
    wb_trap_load = 1'b0;
    case (state)
      IDLE: begin
        if (misalign) begin
          wb_trap_load = 1'b1;
        end else if (mem_op) begin
          stall     = 1'b1;
          capture   = 1'b1;
          state_nxt = ACCESS;
        end else if (in_valid) begin
          wb_alu_load = 1'b1;
        end
      end
      ACCESS: begin
        mem_req = 1'b1;
        stall   = ~mem_ack;
        if (mem_ack) begin
          wb_mem_load = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Upstream must not see a stall while the stage is being reset.
    if (reset) stall = 1'b0;
  end

  assign mem_we    = mem_req & req_we;
  assign mem_addr  = req_addr;
  assign mem_wdata = req_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_we        <= 1'b0;
      req_regwrite  <= 1'b0;
      req_memtoreg  <= 1'b0;
      req_addr      <= '0;
      req_wdata     <= '0;
      req_rd        <= '0;
      wb_valid      <= 1'b0;
      RegWrite_Out  <= 1'b0;
      MemtoReg_Out  <= 1'b0;
      ReadData      <= '0;
      AluResult_Out <= '0;
      Rd_out        <= '0;
    end else begin
      if (capture) begin
        req_we       <= MemWrite;
        req_regwrite <= RegWrite;
        req_memtoreg <= MemtoReg;
        req_addr     <= AluOut;
        req_wdata    <= DataOut;
        req_rd       <= Rd_in;
      end
      wb_valid <= wb_alu_load | wb_mem_load | wb_trap_load;
      if (wb_alu_load | wb_trap_load) begin
        RegWrite_Out  <= RegWrite & ~wb_trap_load;
        MemtoReg_Out  <= MemtoReg;
        AluResult_Out <= AluOut;
        Rd_out        <= Rd_in;
      end
      if (wb_mem_load) begin
        RegWrite_Out  <= req_regwrite;
        MemtoReg_Out  <= req_memtoreg;
        AluResult_Out <= req_addr;
        Rd_out        <= req_rd;
        // A combined MemtoReg+MemWrite op is a store, so it leaves ReadData alone.
        if (req_memtoreg & ~req_we) ReadData <= mem_rdata;
      end
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) misalign_fault <= 1'b0;
    else       misalign_fault <= wb_trap_load;
  end
`else
  assign misalign_fault = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Testbench for mem_stage_ctrl: per-cycle vector table plus hand sequences for reset and misalign.
module tb_mem_stage_ctrl;

  localparam int DATA_W = 64;
  localparam int REG_W  = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid, RegWrite, MemtoReg, MemWrite;
  logic [DATA_W-1:0] AluOut, DataOut;
  logic [REG_W-1:0]  Rd_in;
  logic              stall, mem_req, mem_we;
  logic [DATA_W-1:0] mem_addr, mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              wb_valid, RegWrite_Out, MemtoReg_Out;
  logic [DATA_W-1:0] ReadData, AluResult_Out;
  logic [REG_W-1:0]  Rd_out;
  logic              misalign_fault;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .MemWrite(MemWrite), .AluOut(AluOut), .DataOut(DataOut),
    .Rd_in(Rd_in), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .wb_valid(wb_valid), .RegWrite_Out(RegWrite_Out),
    .MemtoReg_Out(MemtoReg_Out), .ReadData(ReadData), .AluResult_Out(AluResult_Out),
    .Rd_out(Rd_out), .misalign_fault(misalign_fault)
  );

  typedef struct {
    logic              iv, rw, m2r, mw;
    logic [DATA_W-1:0] alu, dout;
    logic [REG_W-1:0]  rd;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              e_stall, e_req, e_we;
    logic [DATA_W-1:0] e_addr, e_wdata;
    logic              e_wbv, e_rwo, e_m2ro;
    logic [DATA_W-1:0] e_rdd, e_alu;
    logic [REG_W-1:0]  e_rdo;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic rw, input logic m2r, input logic mw,
                       input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] dout,
                       input logic [REG_W-1:0] rd, input logic ack, input logic [DATA_W-1:0] rdata);
    in_valid = iv; RegWrite = rw; MemtoReg = m2r; MemWrite = mw;
    AluOut = alu; DataOut = dout; Rd_in = rd; mem_ack = ack; mem_rdata = rdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          iv rw m2r mw alu       dout     rd ack rdata         stall req we addr    wdata     wbv rwo m2ro rdd           alu      rdo
    vecs[0]  = '{1, 1, 0, 0, 'h1234, 0,      7, 0, 0,            0, 0, 0, 0,      0,       1, 1, 0, 0,            'h1234, 7};
    vecs[1]  = '{0, 0, 0, 0, 0,      0,      0, 0, 0,            0, 0, 0, 0,      0,       0, 1, 0, 0,            'h1234, 7};
    vecs[2]  = '{1, 1, 1, 0, 'h40,   0,      3, 0, 0,            1, 0, 0, 0,      0,       0, 1, 0, 0,            'h1234, 7};
    vecs[3]  = '{1, 1, 1, 0, 'h40,   0,      3, 0, 0,            1, 1, 0, 'h40,   0,       0, 1, 0, 0,            'h1234, 7};
    vecs[4]  = '{1, 1, 1, 0, 'h40,   0,      3, 0, 0,            1, 1, 0, 'h40,   0,       0, 1, 0, 0,            'h1234, 7};
    vecs[5]  = '{1, 1, 1, 0, 'h40,   0,      3, 1, 'hDEADBEEF,   0, 1, 0, 'h40,   0,       1, 1, 1, 'hDEADBEEF,   'h40,   3};
    vecs[6]  = '{1, 0, 0, 1, 'h80,   'hCAFE, 0, 0, 0,            1, 0, 0, 0,      0,       0, 1, 1, 'hDEADBEEF,   'h40,   3};
    vecs[7]  = '{1, 0, 0, 1, 'h80,   'hCAFE, 0, 1, 'h5555,       0, 1, 1, 'h80,   'hCAFE,  1, 0, 0, 'hDEADBEEF,   'h80,   0};
    vecs[8]  = '{1, 1, 1, 0, 'h100,  0,      4, 0, 0,            1, 0, 0, 0,      0,       0, 0, 0, 'hDEADBEEF,   'h80,   0};
    vecs[9]  = '{1, 0, 0, 1, 'h200,  'h33,   9, 0, 0,            1, 1, 0, 'h100,  0,       0, 0, 0, 'hDEADBEEF,   'h80,   0};
    vecs[10] = '{1, 0, 0, 1, 'h200,  'h33,   9, 1, 'h11,         0, 1, 0, 'h100,  0,       1, 1, 1, 'h11,         'h100,  4};
    vecs[11] = '{1, 1, 1, 0, 'h108,  0,      5, 0, 0,            1, 0, 0, 0,      0,       0, 1, 1, 'h11,         'h100,  4};
    vecs[12] = '{1, 1, 1, 0, 'h108,  0,      5, 1, 'h22,         0, 1, 0, 'h108,  0,       1, 1, 1, 'h22,         'h108,  5};
    vecs[13] = '{0, 0, 0, 0, 0,      0,      0, 1, 'h44,         0, 0, 0, 0,      0,       0, 1, 1, 'h22,         'h108,  5};
    vecs[14] = '{1, 0, 1, 1, 'h10,   'h77,   6, 0, 0,            1, 0, 0, 0,      0,       0, 1, 1, 'h22,         'h108,  5};
    vecs[15] = '{1, 0, 1, 1, 'h10,   'h77,   6, 1, 'h99,         0, 1, 1, 'h10,   'h77,    1, 0, 1, 'h22,         'h10,   6};

    // Reset with a memory op presented: everything must read zero and stall must stay low.
    reset = 1'b1;
    drive(1, 1, 1, 0, 'h40, 0, 3, 1, 0);
    #3;
    chk("rst_stall", stall, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_regwrite_out", RegWrite_Out, 0);
    chk("rst_readdata", ReadData, 0);
    chk("rst_aluresult", AluResult_Out, 0);
    chk("rst_rd_out", Rd_out, 0);
    chk("rst_fault", misalign_fault, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    step();

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].iv, vecs[i].rw, vecs[i].m2r, vecs[i].mw, vecs[i].alu,
            vecs[i].dout, vecs[i].rd, vecs[i].ack, vecs[i].rdata);
      #1;
      chk($sformatf("v%0d_stall", i), stall, vecs[i].e_stall);
      chk($sformatf("v%0d_mem_req", i), mem_req, vecs[i].e_req);
      if (vecs[i].e_req) begin
        chk($sformatf("v%0d_mem_we", i), mem_we, vecs[i].e_we);
        chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
        chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_wdata);
      end
      step();
      chk($sformatf("v%0d_wb_valid", i), wb_valid, vecs[i].e_wbv);
      chk($sformatf("v%0d_regwrite_out", i), RegWrite_Out, vecs[i].e_rwo);
      chk($sformatf("v%0d_memtoreg_out", i), MemtoReg_Out, vecs[i].e_m2ro);
      chk($sformatf("v%0d_readdata", i), ReadData, vecs[i].e_rdd);
      chk($sformatf("v%0d_aluresult", i), AluResult_Out, vecs[i].e_alu);
      chk($sformatf("v%0d_rd_out", i), Rd_out, vecs[i].e_rdo);
      chk($sformatf("v%0d_fault", i), misalign_fault, 0);
    end

    // Reset while a load is outstanding, then a late ack.
    drive(1, 1, 1, 0, 'h48, 0, 2, 0, 0);
    step();
    chk("midrst_req_before", mem_req, 1);
    reset = 1'b1;
    #1;
    chk("midrst_req_drop", mem_req, 0);
    chk("midrst_stall", stall, 0);
    chk("midrst_wb_valid", wb_valid, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 'hBAD);
    #1;
    reset = 1'b0;
    step();
    chk("midrst_late_ack_wbv", wb_valid, 0);
    chk("midrst_late_ack_req", mem_req, 0);
    chk("midrst_readdata", ReadData, 0);
    step();
    chk("midrst_idle_req", mem_req, 0);
    chk("midrst_idle_wbv", wb_valid, 0);
    chk("midrst_idle_stall", stall, 0);

    // Misaligned load at 0x43.
    drive(1, 1, 1, 0, 'h43, 0, 8, 0, 0);
    #1;
`ifdef MEM_MISALIGN_TRAP_EN
    chk("mis_stall", stall, 0);
    chk("mis_req_pre", mem_req, 0);
    step();
    chk("mis_wb_valid", wb_valid, 1);
    chk("mis_regwrite_out", RegWrite_Out, 0);
    chk("mis_fault", misalign_fault, 1);
    chk("mis_rd_out", Rd_out, 8);
    chk("mis_aluresult", AluResult_Out, 'h43);
    chk("mis_req_post", mem_req, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("mis_fault_clear", misalign_fault, 0);
    chk("mis_req_after", mem_req, 0);
    chk("mis_wbv_after", wb_valid, 0);
`else
    chk("mis_stall", stall, 1);
    step();
    chk("mis_req", mem_req, 1);
    chk("mis_addr", mem_addr, 'h43);
    chk("mis_we", mem_we, 0);
    chk("mis_fault", misalign_fault, 0);
    mem_ack = 1'b1;
    mem_rdata = 'h5A;
    #1;
    chk("mis_stall_ack", stall, 0);
    step();
    chk("mis_wb_valid", wb_valid, 1);
    chk("mis_readdata", ReadData, 'h5A);
    chk("mis_rd_out", Rd_out, 8);
    chk("mis_fault_post", misalign_fault, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
